// File: rtl/kl8_pkg.sv
// Shared constants for the keyboard receive buffer: IOT function bits,
// capture FSM encoding and the stored entry width.
package kl8_pkg;

    localparam int KSF_BIT = 0;
    localparam int KCC_BIT = 1;
    localparam int KRS_BIT = 2;

    // One stored entry is {framing error, data byte}.
    localparam int ENTRY_W = 9;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_ACK  = 2'd1,
        CAP_WAIT = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with the head entry visible combinationally.
// Pop on empty is ignored; a push while full is accepted only alongside a real pop.
module sync_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_reg [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset; contents are only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/kl8_rx_fifo.sv
// PDP-8 keyboard receive buffer: captures receiver bytes into a FIFO and
// serves them through the KSF/KCC/KRS/KRB IOTs with a registered response.
module kl8_rx_fifo
    import kl8_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter bit FORCE_MARK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic       rx_err,
    output logic       rx_read,
    input  logic       iot,
    input  logic [2:0] iot_fn,
    output logic       io_skip,
    output logic       io_ac_clr,
    output logic       io_data_en,
    output logic [7:0] io_data,
    output logic       kbd_flag,
    output logic       kbd_err,
    output logic       int_req,
    output logic       ovf
);
    localparam logic [7:0] MARK = FORCE_MARK ? 8'h80 : 8'h00;

    cap_state_t            state_reg;
    cap_state_t            state_next;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    head;
    logic [DEPTH_LOG2:0]   count;
    logic [7:0]            head_byte;

    logic                  skip_reg;
    logic                  ac_clr_reg;
    logic                  data_en_reg;
    logic [7:0]            hold_reg;
    logic                  ovf_reg;

    assign push = (state_reg == CAP_IDLE) && rx_rdy;
    assign pop  = iot && iot_fn[KCC_BIT];

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({rx_err, rx_data}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CAP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT holds off re-capture until the receiver has dropped rdy.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CAP_IDLE: if (rx_rdy) state_next = CAP_ACK;
            CAP_ACK:  state_next = CAP_WAIT;
            CAP_WAIT: if (!rx_rdy) state_next = CAP_IDLE;
            default:  state_next = CAP_IDLE;
        endcase
    end

    always_comb begin
        rx_read = (state_reg == CAP_ACK);
    end

    assign head_byte = empty ? 8'h00 : (head[7:0] | MARK);

    // The head is popped on the strobe edge, so KRS/KRB return a held copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_reg    <= 1'b0;
            ac_clr_reg  <= 1'b0;
            data_en_reg <= 1'b0;
            hold_reg    <= 8'h00;
            ovf_reg     <= 1'b0;
        end else begin
            skip_reg    <= iot && iot_fn[KSF_BIT] && kbd_flag;
            ac_clr_reg  <= pop;
            data_en_reg <= iot && iot_fn[KRS_BIT];
            if (iot) begin
                hold_reg <= head_byte;
            end
            if (push && full && !pop) begin
                ovf_reg <= 1'b1;
            end else if (pop) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign io_skip    = skip_reg;
    assign io_ac_clr  = ac_clr_reg;
    assign io_data_en = data_en_reg;
    assign io_data    = data_en_reg ? hold_reg : head_byte;
    assign kbd_flag   = (count != '0);
    assign int_req    = kbd_flag;
    assign kbd_err    = !empty && head[8];
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_kl8_rx_fifo.sv
// Bench for kl8_rx_fifo: queue-based reference checked every cycle plus
// directed scenarios with literal expected values.
module tb_kl8_rx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_read;
    logic       iot;
    logic [2:0] iot_fn;
    logic       io_skip;
    logic       io_ac_clr;
    logic       io_data_en;
    logic [7:0] io_data;
    logic       kbd_flag;
    logic       kbd_err;
    logic       int_req;
    logic       ovf;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    kl8_rx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_read    (rx_read),
        .iot        (iot),
        .iot_fn     (iot_fn),
        .io_skip    (io_skip),
        .io_ac_clr  (io_ac_clr),
        .io_data_en (io_data_en),
        .io_data    (io_data),
        .kbd_flag   (kbd_flag),
        .kbd_err    (kbd_err),
        .int_req    (int_req),
        .ovf        (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of {err,data}, a sticky overflow bit, the receiver
    // handshake phase (0 ready to take, 1 acknowledging, 2 waiting for rdy low)
    // and the response expected in the cycle after an IOT strobe.
    logic [8:0] q[$];
    bit         m_ovf;
    int         phase;
    bit         e_skip, e_clr, e_den;
    logic [7:0] e_hold;
    bit         started = 0;
    bit         cap;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf  = 0;
            phase  = 0;
            e_skip = 0;
            e_clr  = 0;
            e_den  = 0;
            e_hold = 8'h00;
        end else begin
            e_skip = iot && iot_fn[0] && (q.size() > 0);
            e_clr  = iot && iot_fn[1];
            e_den  = iot && iot_fn[2];
            if (iot) e_hold = (q.size() > 0) ? (q[0][7:0] | 8'h80) : 8'h00;
            cap = (phase == 0) && rx_rdy;
            if (iot && iot_fn[1]) begin
                m_ovf = 0;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (cap) begin
                if (q.size() < 16) q.push_back({rx_err, rx_data});
                else m_ovf = 1;
            end
            case (phase)
                0:       phase = rx_rdy ? 1 : 0;
                1:       phase = 2;
                default: phase = rx_rdy ? 2 : 0;
            endcase
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_rx_read",  rx_read,    phase == 1);
            chk("m_kbd_flag", kbd_flag,   q.size() > 0);
            chk("m_int_req",  int_req,    q.size() > 0);
            chk("m_kbd_err",  kbd_err,    (q.size() > 0) ? q[0][8] : 1'b0);
            chk("m_io_data",  io_data,    e_den ? e_hold : ((q.size() > 0) ? (q[0][7:0] | 8'h80) : 8'h00));
            chk("m_io_skip",  io_skip,    e_skip);
            chk("m_io_ac_clr", io_ac_clr, e_clr);
            chk("m_io_data_en", io_data_en, e_den);
            chk("m_ovf",      ovf,        m_ovf);
        end
    end

    // Receiver: hold rdy until acknowledged, then leave it low for a cycle.
    task automatic send_byte(input logic [7:0] d, input logic e);
        int n;
        n = 0;
        @(negedge clk);
        rx_rdy = 1'b1; rx_data = d; rx_err = e;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_read && n < 8);
        chk("rx_read_seen", rx_read, 1);
        rx_rdy = 1'b0;
        @(negedge clk);
        chk("rx_read_one_cycle", rx_read, 0);
        @(negedge clk);
    endtask

    // Returns at the negedge of the response cycle.
    task automatic do_iot(input logic [2:0] fn);
        @(negedge clk);
        iot = 1'b1; iot_fn = fn;
        @(negedge clk);
        iot = 1'b0; iot_fn = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
        iot = 1'b0; iot_fn = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_rx_read", rx_read, 0);
        chk("rst_flag", kbd_flag, 0);
        chk("rst_int", int_req, 0);
        chk("rst_err", kbd_err, 0);
        chk("rst_data", io_data, 8'h00);
        chk("rst_ovf", ovf, 0);
        chk("rst_io", {io_skip, io_ac_clr, io_data_en}, 3'b000);
        rst = 1'b0;

        // Single byte through KRB
        send_byte(8'h41, 1'b0);
        chk("single_flag", kbd_flag, 1);
        chk("single_int", int_req, 1);
        do_iot(3'd6);
        chk("krb_clr", io_ac_clr, 1);
        chk("krb_den", io_data_en, 1);
        chk("krb_data", io_data, 8'hC1);
        chk("krb_flag_after", kbd_flag, 0);

        // Skip and non-destructive KRS
        do_iot(3'd1);
        chk("ksf_empty", io_skip, 0);
        send_byte(8'h0D, 1'b0);
        do_iot(3'd1);
        chk("ksf_full", io_skip, 1);
        for (int k = 0; k < 2; k++) begin
            do_iot(3'd4);
            chk("krs_data", io_data, 8'h8D);
            chk("krs_den", io_data_en, 1);
            chk("krs_noclr", io_ac_clr, 0);
            chk("krs_flag", kbd_flag, 1);
        end
        do_iot(3'd0);
        chk("fn0_den", io_data_en, 0);
        chk("fn0_flag", kbd_flag, 1);
        do_iot(3'd6);
        chk("krb_0d", io_data, 8'h8D);

        // Fill, overflow, ordered drain
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_flag", kbd_flag, 1);
        for (int i = 0; i < 16; i++) begin
            do_iot(3'd6);
            chk("drain_data", io_data, 8'h80 + 8'(i));
            if (i == 0) chk("ovf_cleared", ovf, 0);
        end
        chk("drain_empty", kbd_flag, 0);

        // Framing error travels with its byte
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        chk("err_head", kbd_err, 1);
        chk("err_head_data", io_data, 8'hD5);
        do_iot(3'd2);
        chk("kcc_clr", io_ac_clr, 1);
        chk("kcc_noden", io_data_en, 0);
        chk("err_next", kbd_err, 0);
        chk("err_next_data", io_data, 8'hE6);
        do_iot(3'd6);
        chk("err_drain", io_data, 8'hE6);

        // Full FIFO with KRB and a new byte on the same edge
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0);
        @(negedge clk);
        iot = 1'b1; iot_fn = 3'd6;
        rx_rdy = 1'b1; rx_data = 8'h30; rx_err = 1'b0;
        @(negedge clk);
        iot = 1'b0; iot_fn = 3'd0;
        chk("sim_data", io_data, 8'hA0);
        chk("sim_ack", rx_read, 1);
        chk("sim_ovf", ovf, 0);
        rx_rdy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 1; i < 17; i++) begin
            do_iot(3'd6);
            chk("sim_drain", io_data, 8'hA0 + 8'(i));
        end
        chk("sim_empty", kbd_flag, 0);
        chk("sim_ovf_end", ovf, 0);

        // Reset during the acknowledge cycle
        @(negedge clk);
        rx_rdy = 1'b1; rx_data = 8'h5A; rx_err = 1'b0;
        @(negedge clk);
        chk("pre_rst_ack", rx_read, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack_drop", rx_read, 0);
        chk("rst_ack_empty", kbd_flag, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("recap_ack", rx_read, 1);
        chk("recap_flag", kbd_flag, 1);
        rx_rdy = 1'b0;
        repeat (2) @(negedge clk);
        do_iot(3'd6);
        chk("recap_data", io_data, 8'hDA);
        chk("recap_once", kbd_flag, 0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
